// File: rtl/regfile_port_arbiter.sv
// Shares one regfile read port and one write port among NREQ requesters with round-robin grant.
// Define REGARB_FIXED_PRIO_EN to replace round-robin with fixed lowest-index-wins priority.

module regfile_port_arbiter #(
  parameter int NREQ = 3,
  parameter int RW   = 4,
  parameter int DW   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      rd_req,
  input  logic [NREQ*RW-1:0]   rd_reg,
  output logic [NREQ-1:0]      rd_ack,
  output logic [DW-1:0]        rd_data,
  input  logic [NREQ-1:0]      wr_req,
  input  logic [NREQ*RW-1:0]   wr_reg,
  input  logic [NREQ*DW-1:0]   wr_value,
  input  logic [NREQ-1:0]      wr_spsr,
  output logic [NREQ-1:0]      wr_ack,
  output logic                 reg_read_en,
  output logic [RW-1:0]        reg_read_reg,
  input  logic [DW-1:0]        reg_read_value,
  output logic                 reg_write_en,
  output logic [RW-1:0]        reg_write_reg,
  output logic [DW-1:0]        reg_write_value,
  output logic                 reg_write_restore_from_SPSR,
  output logic                 busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {R_IDLE = 2'd0, R_ISSUE = 2'd1, R_WAIT = 2'd2, R_ACK = 2'd3} rd_state_t;
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_ISSUE = 2'd1, W_ACK = 2'd2} wr_state_t;

  rd_state_t     rd_state_r;
  wr_state_t     wr_state_r;
  logic [IW-1:0] rd_gnt_r, wr_gnt_r;
  logic [IW-1:0] rd_ptr_s, wr_ptr_s;
  logic [IW:0]   rd_pick_s, wr_pick_s;
  logic          rd_hazard_s, rd_go_s;
  logic [RW-1:0] rd_reg_a_s   [NREQ];
  logic [RW-1:0] wr_reg_a_s   [NREQ];
  logic [DW-1:0] wr_value_a_s [NREQ];

  // Returns {valid, index} of the first set request scanning from ptr upward, wrapping mod NREQ.
  function automatic logic [IW:0] pick(input logic [NREQ-1:0] req, input logic [IW-1:0] ptr);
    logic [IW:0]   res;
    logic [IW-1:0] idx;
    int            k;
    res = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      k   = int'(ptr) + i;
      idx = IW'((k >= NREQ) ? k - NREQ : k);
      if (req[idx]) res = {1'b1, idx};
      else          res = res;
    end
    return res;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] g);
    return {{(NREQ-1){1'b0}}, 1'b1} << g;
  endfunction

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign rd_reg_a_s[i]   = rd_reg[i*RW +: RW];
    assign wr_reg_a_s[i]   = wr_reg[i*RW +: RW];
    assign wr_value_a_s[i] = wr_value[i*DW +: DW];
  end

`ifdef REGARB_FIXED_PRIO_EN
  assign rd_ptr_s = '0;
  assign wr_ptr_s = '0;
`else
  logic [IW-1:0] rd_rr_r, wr_rr_r;

  function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] g);
    logic [IW-1:0] n;
    if (g == IW'(NREQ - 1)) n = '0;
    else                    n = g + IW'(1);
    return n;
  endfunction

  assign rd_ptr_s = rd_rr_r;
  assign wr_ptr_s = wr_rr_r;

  // Round-robin pointers advance past the granted requester as its ack retires.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_rr_r <= '0;
      wr_rr_r <= '0;
    end else begin
      if (rd_state_r == R_ACK) rd_rr_r <= next_ptr(rd_gnt_r);
      else                     rd_rr_r <= rd_rr_r;
      if (wr_state_r == W_ACK) wr_rr_r <= next_ptr(wr_gnt_r);
      else                     wr_rr_r <= wr_rr_r;
    end
  end
`endif

  // Grant selection; a read waits while the write being issued targets the same register.
  always_comb begin
    rd_pick_s   = pick(rd_req, rd_ptr_s);
    wr_pick_s   = pick(wr_req, wr_ptr_s);
    rd_hazard_s = (wr_state_r == W_ISSUE) && (reg_write_reg == rd_reg_a_s[rd_pick_s[IW-1:0]]);
    rd_go_s     = rd_pick_s[IW] && !rd_hazard_s;
  end

  // Read sequencer: issue, wait one cycle for regfile data, then capture and acknowledge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_state_r   <= R_IDLE;
      rd_gnt_r     <= '0;
      rd_ack       <= '0;
      rd_data      <= '0;
      reg_read_en  <= 1'b0;
      reg_read_reg <= '0;
    end else begin
      case (rd_state_r)
        R_IDLE: begin
          if (rd_go_s) begin
            rd_gnt_r     <= rd_pick_s[IW-1:0];
            reg_read_reg <= rd_reg_a_s[rd_pick_s[IW-1:0]];
            reg_read_en  <= 1'b1;
            rd_state_r   <= R_ISSUE;
          end
        end
        R_ISSUE: begin
          reg_read_en <= 1'b0;
          rd_state_r  <= R_WAIT;
        end
        R_WAIT: begin
          rd_data    <= reg_read_value;
          rd_ack     <= onehot(rd_gnt_r);
          rd_state_r <= R_ACK;
        end
        R_ACK: begin
          rd_ack     <= '0;
          rd_state_r <= R_IDLE;
        end
        default: begin
          rd_state_r  <= R_IDLE;
          reg_read_en <= 1'b0;
          rd_ack      <= '0;
        end
      endcase
    end
  end

  // Write sequencer: one issue cycle with operands latched at grant, then acknowledge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_state_r                  <= W_IDLE;
      wr_gnt_r                    <= '0;
      wr_ack                      <= '0;
      reg_write_en                <= 1'b0;
      reg_write_reg               <= '0;
      reg_write_value             <= '0;
      reg_write_restore_from_SPSR <= 1'b0;
    end else begin
      case (wr_state_r)
        W_IDLE: begin
          if (wr_pick_s[IW]) begin
            wr_gnt_r                    <= wr_pick_s[IW-1:0];
            reg_write_reg               <= wr_reg_a_s[wr_pick_s[IW-1:0]];
            reg_write_value             <= wr_value_a_s[wr_pick_s[IW-1:0]];
            reg_write_restore_from_SPSR <= wr_spsr[wr_pick_s[IW-1:0]];
            reg_write_en                <= 1'b1;
            wr_state_r                  <= W_ISSUE;
          end
        end
        W_ISSUE: begin
          reg_write_en                <= 1'b0;
          reg_write_restore_from_SPSR <= 1'b0;
          wr_ack                      <= onehot(wr_gnt_r);
          wr_state_r                  <= W_ACK;
        end
        W_ACK: begin
          wr_ack     <= '0;
          wr_state_r <= W_IDLE;
        end
        default: begin
          wr_state_r                  <= W_IDLE;
          reg_write_en                <= 1'b0;
          reg_write_restore_from_SPSR <= 1'b0;
          wr_ack                      <= '0;
        end
      endcase
    end
  end

  assign busy = (rd_state_r != R_IDLE) || (wr_state_r != W_IDLE) || (|rd_req) || (|wr_req);

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Directed, table-driven bench for regfile_port_arbiter with a small regfile model
// (address latched on reg_read_en, data presented the following cycle).

module tb_regfile_port_arbiter;

  localparam int NREQ = 3;
  localparam int RW   = 4;
  localparam int DW   = 32;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NREQ-1:0]     rd_req, rd_ack, wr_req, wr_ack, wr_spsr;
  logic [NREQ*RW-1:0]  rd_reg, wr_reg;
  logic [NREQ*DW-1:0]  wr_value;
  logic [DW-1:0]       rd_data, reg_read_value, reg_write_value;
  logic                reg_read_en, reg_write_en, reg_write_restore_from_SPSR, busy;
  logic [RW-1:0]       reg_read_reg, reg_write_reg;

  always #5 clk = ~clk;

  regfile_port_arbiter #(.NREQ(NREQ), .RW(RW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_req(rd_req), .rd_reg(rd_reg), .rd_ack(rd_ack), .rd_data(rd_data),
    .wr_req(wr_req), .wr_reg(wr_reg), .wr_value(wr_value), .wr_spsr(wr_spsr), .wr_ack(wr_ack),
    .reg_read_en(reg_read_en), .reg_read_reg(reg_read_reg), .reg_read_value(reg_read_value),
    .reg_write_en(reg_write_en), .reg_write_reg(reg_write_reg), .reg_write_value(reg_write_value),
    .reg_write_restore_from_SPSR(reg_write_restore_from_SPSR), .busy(busy)
  );

  // Regfile model
  logic [31:0] mem [16];
  logic [3:0]  rf_addr_r = 4'h0;
  logic        pre_en;
  logic [3:0]  pre_addr;
  logic [31:0] pre_data;

  always @(posedge clk) begin
    if (reg_read_en) rf_addr_r <= reg_read_reg;
    if (reg_write_en) mem[reg_write_reg] <= reg_write_value;
    else if (pre_en) mem[pre_addr] <= pre_data;
  end
  assign reg_read_value = mem[rf_addr_r];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic preload(input logic [3:0] a, input logic [31:0] d);
    pre_addr = a; pre_data = d; pre_en = 1'b1;
    @(posedge clk); #1;
    pre_en = 1'b0;
  endtask

  int          ren_cnt, wen_cnt;
  logic [3:0]  ren_reg, wen_reg;
  logic [31:0] wen_val;
  logic        wen_sp;

  // Write request at cycle 0, read request at cycle rdly; latencies counted from each request.
  task automatic run_pair(input bit do_w, input int wi, input logic [3:0] wrg, input logic [31:0] wv,
                          input logic ws, input bit do_r, input int rdly, input int ri,
                          input logic [3:0] rrg, output int wlat, output int rlat,
                          output logic [2:0] wack, output logic [2:0] rack, output logic [31:0] rdat);
    int c;
    bit wdone, rdone;
    wlat = -1; rlat = -1; wack = '0; rack = '0; rdat = '0;
    ren_cnt = 0; wen_cnt = 0; ren_reg = '0; wen_reg = '0; wen_val = '0; wen_sp = 1'b0;
    wdone = !do_w; rdone = !do_r; c = 0;
    if (do_w) begin
      wr_reg[wi*4 +: 4] = wrg; wr_value[wi*32 +: 32] = wv; wr_spsr[wi] = ws; wr_req[wi] = 1'b1;
    end
    while (!(wdone && rdone) && c < 20) begin
      if (do_r && c == rdly) begin
        rd_reg[ri*4 +: 4] = rrg; rd_req[ri] = 1'b1;
      end
      @(posedge clk); #1; c++;
      if (reg_read_en) begin ren_cnt++; ren_reg = reg_read_reg; end
      if (reg_write_en) begin
        wen_cnt++; wen_reg = reg_write_reg; wen_val = reg_write_value; wen_sp = reg_write_restore_from_SPSR;
      end
      if (!wdone && wr_ack != 3'b000) begin
        wdone = 1'b1; wlat = c; wack = wr_ack; wr_req = '0;
      end
      if (!rdone && rd_ack != 3'b000) begin
        rdone = 1'b1; rlat = c - rdly; rack = rd_ack; rdat = rd_data; rd_req = '0;
      end
    end
    rd_req = '0; wr_req = '0;
    @(posedge clk); #1;
  endtask

  logic [2:0] ack_log [8];
  int         lat_log [8];
  int         ack_n;

  task automatic collect(input bit is_wr, input int n, input logic [2:0] req, input bit drop);
    int cyc;
    logic [2:0] a;
    for (int k = 0; k < 8; k++) begin ack_log[k] = 3'b000; lat_log[k] = -1; end
    ack_n = 0; cyc = 0;
    if (is_wr) wr_req = req; else rd_req = req;
    while (ack_n < n && cyc < 80) begin
      @(posedge clk); #1; cyc++;
      a = is_wr ? wr_ack : rd_ack;
      if (a != 3'b000) begin
        ack_log[ack_n] = a; lat_log[ack_n] = cyc; ack_n++;
        if (drop) begin
          if (is_wr) wr_req = wr_req & ~a;
          else       rd_req = rd_req & ~a;
        end
      end
    end
    rd_req = '0; wr_req = '0;
    @(posedge clk); #1;
  endtask

  typedef struct {
    int          ri;
    logic [3:0]  rg;
    logic [31:0] val;
    logic [2:0]  exp_ack;
    logic [31:0] exp_data;
    int          exp_lat;
  } rd_vec_t;

  typedef struct {
    int          wi;
    logic [3:0]  rg;
    logic [31:0] val;
    logic        sp;
    logic [2:0]  exp_ack;
    int          exp_lat;
  } wr_vec_t;

  rd_vec_t rdv [4];
  wr_vec_t wrv [3];

  initial begin
    int          wl, rl, nack;
    logic [2:0]  wa, ra;
    logic [31:0] rd_v;
    logic [2:0]  exp_held [3];

    rdv[0] = '{0, 4'd15, 32'h0000_0100, 3'b001, 32'h0000_0100, 3};
    rdv[1] = '{1, 4'd3,  32'hDEAD_BEEF, 3'b010, 32'hDEAD_BEEF, 3};
    rdv[2] = '{2, 4'd0,  32'hFFFF_FFFF, 3'b100, 32'hFFFF_FFFF, 3};
    rdv[3] = '{1, 4'd9,  32'h0000_0000, 3'b010, 32'h0000_0000, 3};
    wrv[0] = '{0, 4'd10, 32'h1234_5678, 1'b0, 3'b001, 2};
    wrv[1] = '{2, 4'd7,  32'hA5A5_5A5A, 1'b1, 3'b100, 2};
    wrv[2] = '{1, 4'd0,  32'h0000_0001, 1'b0, 3'b010, 2};
`ifdef REGARB_FIXED_PRIO_EN
    exp_held = '{3'b001, 3'b001, 3'b001};
`else
    exp_held = '{3'b001, 3'b010, 3'b100};
`endif

    rst_n = 1'b0; rd_req = 3'b111; wr_req = '0; rd_reg = '0; wr_reg = '0;
    wr_value = '0; wr_spsr = '0; pre_en = 1'b0; pre_addr = '0; pre_data = '0;

    // Reset held two cycles with all read requests up
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk($sformatf("rst%0d_strobes", i),
          64'({rd_ack, wr_ack, reg_read_en, reg_write_en, reg_write_restore_from_SPSR}), 64'h0);
    end
    chk("rst_rd_data", 64'(rd_data), 64'h0);
    chk("rst_rd_reg", 64'(reg_read_reg), 64'h0);
    chk("rst_wr_regval", 64'({reg_write_reg, reg_write_value}), 64'h0);
    rst_n = 1'b1;
    collect(1'b0, 1, 3'b111, 1'b1);
    chk("rst_release_ack", 64'(ack_log[0]), 64'(3'b001));
    chk("rst_release_lat", 64'(lat_log[0]), 64'(3));
    chk("idle_busy", 64'(busy), 64'h0);

    for (int i = 0; i < 4; i++) begin
      preload(rdv[i].rg, rdv[i].val);
      run_pair(1'b0, 0, 4'd0, 32'h0, 1'b0, 1'b1, 0, rdv[i].ri, rdv[i].rg, wl, rl, wa, ra, rd_v);
      chk($sformatf("rd%0d_ack", i), 64'(ra), 64'(rdv[i].exp_ack));
      chk($sformatf("rd%0d_lat", i), 64'(rl), 64'(rdv[i].exp_lat));
      chk($sformatf("rd%0d_data", i), 64'(rd_v), 64'(rdv[i].exp_data));
      chk($sformatf("rd%0d_en_cnt", i), 64'(ren_cnt), 64'(1));
      chk($sformatf("rd%0d_en_reg", i), 64'(ren_reg), 64'(rdv[i].rg));
    end

    for (int i = 0; i < 3; i++) begin
      run_pair(1'b1, wrv[i].wi, wrv[i].rg, wrv[i].val, wrv[i].sp, 1'b0, 0, 0, 4'd0, wl, rl, wa, ra, rd_v);
      chk($sformatf("wr%0d_ack", i), 64'(wa), 64'(wrv[i].exp_ack));
      chk($sformatf("wr%0d_lat", i), 64'(wl), 64'(wrv[i].exp_lat));
      chk($sformatf("wr%0d_en_cnt", i), 64'(wen_cnt), 64'(1));
      chk($sformatf("wr%0d_port", i), 64'({wen_sp, wen_reg, wen_val}), 64'({wrv[i].sp, wrv[i].rg, wrv[i].val}));
      run_pair(1'b0, 0, 4'd0, 32'h0, 1'b0, 1'b1, 0, (wrv[i].wi + 1) % 3, wrv[i].rg, wl, rl, wa, ra, rd_v);
      chk($sformatf("wr%0d_readback", i), 64'(rd_v), 64'(wrv[i].val));
    end

    // Read r3 and write r5 together: independent ports
    preload(4'd3, 32'h3333_0003);
    run_pair(1'b1, 1, 4'd5, 32'h55, 1'b0, 1'b1, 0, 2, 4'd3, wl, rl, wa, ra, rd_v);
    chk("conc_wlat", 64'(wl), 64'(2));
    chk("conc_rlat", 64'(rl), 64'(3));
    chk("conc_acks", 64'({wa, ra}), 64'({3'b010, 3'b100}));
    chk("conc_data", 64'(rd_v), 64'h3333_0003);

    // Same register, requests in the same cycle: read must see the written value
    preload(4'd15, 32'h0000_0100);
    run_pair(1'b1, 0, 4'd15, 32'h104, 1'b0, 1'b1, 0, 1, 4'd15, wl, rl, wa, ra, rd_v);
    chk("haz_same_data", 64'(rd_v), 64'h104);
    chk("haz_same_acks", 64'({wa, ra}), 64'({3'b001, 3'b010}));

    // Read arrives while the write to its register is issuing: one cycle of stall
    preload(4'd6, 32'h0000_0600);
    run_pair(1'b1, 2, 4'd6, 32'h66, 1'b0, 1'b1, 1, 0, 4'd6, wl, rl, wa, ra, rd_v);
    chk("haz_stall_rlat", 64'(rl), 64'(4));
    chk("haz_stall_data", 64'(rd_v), 64'h66);
    chk("haz_stall_wlat", 64'(wl), 64'(2));

    preload(4'd4, 32'h0000_0044);
    run_pair(1'b1, 2, 4'd6, 32'h77, 1'b0, 1'b1, 1, 0, 4'd4, wl, rl, wa, ra, rd_v);
    chk("haz_diff_rlat", 64'(rl), 64'(3));
    chk("haz_diff_data", 64'(rd_v), 64'h44);

    // Reset while the read sits in its wait cycle
    preload(4'd9, 32'h0000_0999);
    rd_reg[3:0] = 4'd9; rd_req = 3'b001;
    @(posedge clk); #1;
    chk("midrst_en_issue", 64'(reg_read_en), 64'h1);
    @(posedge clk); #1;
    rst_n = 1'b0; rd_req = '0;
    @(posedge clk); #1;
    chk("midrst_outs", 64'({rd_ack, reg_read_en}), 64'h0);
    chk("midrst_data", 64'(rd_data), 64'h0);
    rst_n = 1'b1;
    nack = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (rd_ack != 3'b000) nack++;
    end
    chk("midrst_no_ack", 64'(nack), 64'(0));
    chk("midrst_idle", 64'(busy), 64'h0);
    collect(1'b0, 2, 3'b110, 1'b1);
    chk("post_rst_g0", 64'(ack_log[0]), 64'(3'b010));
    chk("post_rst_g1", 64'(ack_log[1]), 64'(3'b100));

    collect(1'b0, 3, 3'b111, 1'b1);
    for (int k = 0; k < 3; k++) chk($sformatf("rr_a%0d", k), 64'(ack_log[k]), 64'(3'b001 << k));
    collect(1'b0, 3, 3'b111, 1'b1);
    for (int k = 0; k < 3; k++) chk($sformatf("rr_b%0d", k), 64'(ack_log[k]), 64'(3'b001 << k));
    chk("rr_b_spacing", 64'(lat_log[1] - lat_log[0]), 64'(4));

    collect(1'b0, 3, 3'b111, 1'b0);
    for (int k = 0; k < 3; k++) chk($sformatf("held_rd%0d", k), 64'(ack_log[k]), 64'(exp_held[k]));
    collect(1'b1, 3, 3'b111, 1'b0);
    for (int k = 0; k < 3; k++) chk($sformatf("held_wr%0d", k), 64'(ack_log[k]), 64'(exp_held[k]));
    chk("held_wr_spacing", 64'(lat_log[1] - lat_log[0]), 64'(3));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
